// File: rtl/spi_counter_bank.sv
// spi_counter_bank
//   Multi-channel SPI-slave counter peripheral. Holds CH_COUNT counters of
//   CNT_W bits. Each can be read, cleared, incremented or loaded over SPI
//   (mode 0, MSB first). A rising edge on its evt input also increments it.
//   All SPI pins are oversampled in the clk domain. Nothing is clocked by sck.
//
//   Frame: command byte {op[1:0], channel[5:0]}, then CNT_W/8 payload bytes.
//   op 00 READ, 01 CLEAR, 10 INC, 11 LOAD.
//
// Ports
//   clk   system clock, at least 4x sck
//   rst   asynchronous active-high reset
//   ss    slave select, active low
//   sck   SPI clock (CPOL=0, CPHA=0)
//   mosi  serial data in
//   miso  serial data out, 0 whenever read data is not being shifted
//   evt   per-channel hardware increment requests (asynchronous)
module spi_counter_bank #(
    parameter int CH_COUNT    = 4,
    parameter int CNT_W       = 16,
    parameter bit SATURATE    = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ss,
    input  logic                sck,
    input  logic                mosi,
    output logic                miso,
    input  logic [CH_COUNT-1:0] evt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [5:0] CMD_LAST  = 6'd7;
    localparam logic [5:0] DATA_LAST = 6'(CNT_W - 1);
    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_INC    = 2'b10;
    localparam logic [1:0] OP_LOAD   = 2'b11;

    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [CH_COUNT-1:0]    evt_sync_r [SYNC_STAGES];
    logic                   ss_d_r;
    logic                   sck_d_r;
    logic [CH_COUNT-1:0]    evt_d_r;

    logic                   ss_s;
    logic                   sck_s;
    logic                   mosi_s;
    logic [CH_COUNT-1:0]    evt_s;
    logic [CH_COUNT-1:0]    evt_pulse_s;
    logic                   ss_fall_s;
    logic                   sck_rise_s;
    logic                   sck_fall_s;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [5:0]             bit_cnt_r;
    logic [5:0]             bit_cnt_next_s;
    logic [CNT_W-1:0]       shift_r;
    logic [CNT_W-1:0]       shift_next_s;
    logic [CNT_W-1:0]       shifted_s;
    logic [CNT_W-1:0]       tx_r;
    logic [CNT_W-1:0]       tx_next_s;
    logic [5:0]             ch_r;
    logic [5:0]             ch_next_s;
    logic                   clr_r;
    logic                   clr_next_s;
    logic                   inc_r;
    logic                   inc_next_s;
    logic                   ld_r;
    logic                   ld_next_s;
    logic                   miso_r;
    logic                   miso_next_s;
    logic [CNT_W-1:0]       snap_s;

    logic [CH_COUNT-1:0][CNT_W-1:0] cnt_r;
    logic [CH_COUNT-1:0][CNT_W-1:0] cnt_next_s;
    logic [CH_COUNT-1:0][CNT_W:0]   sum_s;

    // Input synchronisers plus one-deep history for edge detection.
    // Chains reset to 0 so that ss held low across reset is not seen as a
    // falling edge: a new frame needs ss to go high and then low again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync_r   <= '0;
            sck_sync_r  <= '0;
            mosi_sync_r <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                evt_sync_r[s] <= '0;
            end
            ss_d_r      <= 1'b0;
            sck_d_r     <= 1'b0;
            evt_d_r     <= '0;
        end else begin
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss};
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            evt_sync_r[0] <= evt;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                evt_sync_r[s] <= evt_sync_r[s-1];
            end
            ss_d_r      <= ss_s;
            sck_d_r     <= sck_s;
            evt_d_r     <= evt_s;
        end
    end

    assign ss_s        = ss_sync_r[SYNC_STAGES-1];
    assign sck_s       = sck_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign evt_s       = evt_sync_r[SYNC_STAGES-1];
    assign ss_fall_s   = ss_d_r & ~ss_s;
    assign sck_rise_s  = sck_s & ~sck_d_r;
    assign sck_fall_s  = sck_d_r & ~sck_s;
    assign evt_pulse_s = evt_s & ~evt_d_r;
    assign shifted_s   = {shift_r[CNT_W-2:0], mosi_s};
    assign miso        = miso_r;

    // Snapshot source for READ: value of the channel named by the command
    // byte being completed; invalid channels read as zero.
    always_comb begin
        snap_s = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (shifted_s[5:0] == 6'(i)) begin
                snap_s = cnt_r[i];
            end else begin
                snap_s = snap_s;
            end
        end
    end

    // Frame FSM: next state, bit counting, shift registers and action strobes.
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        tx_next_s      = tx_r;
        ch_next_s      = ch_r;
        clr_next_s     = 1'b0;
        inc_next_s     = 1'b0;
        ld_next_s      = 1'b0;
        if (ss_s) begin
            state_next_s   = ST_IDLE;
            bit_cnt_next_s = 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        state_next_s   = ST_CMD;
                        bit_cnt_next_s = 6'd0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_s) begin
                        shift_next_s = shifted_s;
                        if (bit_cnt_r == CMD_LAST) begin
                            bit_cnt_next_s = 6'd0;
                            ch_next_s      = shifted_s[5:0];
                            case (shifted_s[7:6])
                                OP_READ: begin
                                    state_next_s = ST_RD;
                                    tx_next_s    = snap_s;
                                end
                                OP_CLEAR: begin
                                    state_next_s = ST_DONE;
                                    clr_next_s   = 1'b1;
                                end
                                OP_INC: begin
                                    state_next_s = ST_DONE;
                                    inc_next_s   = 1'b1;
                                end
                                OP_LOAD: begin
                                    state_next_s = ST_WR;
                                end
                                default: begin
                                    state_next_s = ST_DONE;
                                end
                            endcase
                        end else begin
                            bit_cnt_next_s = bit_cnt_r + 6'd1;
                        end
                    end else begin
                        state_next_s = ST_CMD;
                    end
                end
                ST_RD: begin
                    if (sck_rise_s) begin
                        if (bit_cnt_r == DATA_LAST) begin
                            state_next_s   = ST_DONE;
                            bit_cnt_next_s = 6'd0;
                        end else begin
                            bit_cnt_next_s = bit_cnt_r + 6'd1;
                        end
                    end else if (sck_fall_s && (bit_cnt_r != 6'd0)) begin
                        // The falling edge that closes the command byte must
                        // not shift: the MSB is still waiting to be sampled.
                        tx_next_s = {tx_r[CNT_W-2:0], 1'b0};
                    end else begin
                        state_next_s = ST_RD;
                    end
                end
                ST_WR: begin
                    if (sck_rise_s) begin
                        shift_next_s = shifted_s;
                        if (bit_cnt_r == DATA_LAST) begin
                            state_next_s   = ST_DONE;
                            bit_cnt_next_s = 6'd0;
                            ld_next_s      = 1'b1;
                        end else begin
                            bit_cnt_next_s = bit_cnt_r + 6'd1;
                        end
                    end else begin
                        state_next_s = ST_WR;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_DONE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
        // miso is registered from the next-cycle shift data so the MSB
        // appears one clk after the READ decode.
        if (state_next_s == ST_RD) begin
            miso_next_s = tx_next_s[CNT_W-1];
        end else begin
            miso_next_s = 1'b0;
        end
    end

    // Frame FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 6'd0;
            shift_r   <= '0;
            tx_r      <= '0;
            ch_r      <= 6'd0;
            clr_r     <= 1'b0;
            inc_r     <= 1'b0;
            ld_r      <= 1'b0;
            miso_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            shift_r   <= shift_next_s;
            tx_r      <= tx_next_s;
            ch_r      <= ch_next_s;
            clr_r     <= clr_next_s;
            inc_r     <= inc_next_s;
            ld_r      <= ld_next_s;
            miso_r    <= miso_next_s;
        end
    end

    // Counter next values: CLEAR/LOAD win over increments (evt dropped);
    // SPI INC and evt in the same clk add 2. Sum carries one extra bit so
    // saturation can detect overflow.
    always_comb begin
        cnt_next_s = cnt_r;
        sum_s      = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            sum_s[i] = {1'b0, cnt_r[i]}
                     + {{CNT_W{1'b0}}, (inc_r && (ch_r == 6'(i)))}
                     + {{CNT_W{1'b0}}, evt_pulse_s[i]};
            if (clr_r && (ch_r == 6'(i))) begin
                cnt_next_s[i] = '0;
            end else if (ld_r && (ch_r == 6'(i))) begin
                cnt_next_s[i] = shift_r;
            end else if (SATURATE && sum_s[i][CNT_W]) begin
                cnt_next_s[i] = {CNT_W{1'b1}};
            end else begin
                cnt_next_s[i] = sum_s[i][CNT_W-1:0];
            end
        end
    end

    // Counter bank registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: tb/tb_spi_counter_bank.sv
module tb_spi_counter_bank;

    localparam int CLK_P = 10;
    localparam int HALF  = 80;

    logic       clk;
    logic       rst;
    logic       ss;
    logic       sck;
    logic       mosi;
    logic       miso0;
    logic       miso1;
    logic [3:0] evt;

    int total;
    int bad;

    logic [7:0]  cmd_rx0;
    logic [7:0]  cmd_rx1;
    logic [7:0]  c0, c1;
    logic [15:0] v0, v1;

    spi_counter_bank #(
        .CH_COUNT(4), .CNT_W(16), .SATURATE(1'b0), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi),
        .miso(miso0), .evt(evt)
    );

    spi_counter_bank #(
        .CH_COUNT(4), .CNT_W(16), .SATURATE(1'b1), .SYNC_STAGES(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi),
        .miso(miso1), .evt(evt)
    );

    initial clk = 1'b0;
    always #(CLK_P/2) clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    // Shift nbits of tx MSB first; miso sampled just before each rising edge.
    // A nonzero evt_mask is raised one clk after the last rising edge.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, input logic [3:0] evt_mask,
                             output logic [7:0] rx0, output logic [7:0] rx1);
        rx0 = 8'h00;
        rx1 = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            #(HALF);
            rx0[i] = miso0;
            rx1[i] = miso1;
            sck = 1'b1;
            if (i == 0 && evt_mask != 4'b0000) begin
                #(CLK_P);
                evt = evt_mask;
                #(HALF - CLK_P);
                sck = 1'b0;
                evt = 4'b0000;
            end else begin
                #(HALF);
                sck = 1'b0;
            end
        end
    endtask

    task automatic frame_start();
        ss = 1'b0;
        #(HALF);
    endtask

    task automatic frame_stop();
        #(HALF);
        ss = 1'b1;
        #(4*HALF);
    endtask

    task automatic spi_read(input logic [5:0] ch, output logic [15:0] r0, output logic [15:0] r1);
        logic [7:0] a0, a1, b0, b1;
        frame_start();
        xfer_bits({2'b00, ch}, 8, 4'b0000, cmd_rx0, cmd_rx1);
        xfer_bits(8'h00, 8, 4'b0000, a0, a1);
        xfer_bits(8'h00, 8, 4'b0000, b0, b1);
        frame_stop();
        r0 = {a0, b0};
        r1 = {a1, b1};
    endtask

    task automatic spi_load(input logic [5:0] ch, input logic [15:0] val);
        logic [7:0] d0, d1;
        frame_start();
        xfer_bits({2'b11, ch}, 8, 4'b0000, d0, d1);
        xfer_bits(val[15:8], 8, 4'b0000, d0, d1);
        xfer_bits(val[7:0], 8, 4'b0000, d0, d1);
        frame_stop();
    endtask

    task automatic spi_cmd(input logic [7:0] cmd, input logic [3:0] evt_mask);
        logic [7:0] d0, d1;
        frame_start();
        xfer_bits(cmd, 8, evt_mask, d0, d1);
        frame_stop();
        check("cmd_byte_miso_zero", {d0, d1}, 16'h0000);
    endtask

    task automatic read_check(input string tag, input logic [5:0] ch,
                              input logic [15:0] exp0, input logic [15:0] exp1);
        logic [15:0] r0, r1;
        spi_read(ch, r0, r1);
        check({tag, "_wrap"}, r0, exp0);
        check({tag, "_sat"}, r1, exp1);
    endtask

    task automatic pulse_evt(input logic [3:0] mask);
        evt = mask;
        #(4*CLK_P);
        evt = 4'b0000;
        #(4*CLK_P);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        ss    = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        evt   = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_miso", {14'h0, miso0, miso1}, 16'h0000);
        rst = 1'b0;
        #(4*CLK_P);

        // READ ch0 after reset; miso silent during the command byte
        spi_read(6'd0, v0, v1);
        check("rd0_cmd_miso", {cmd_rx0, cmd_rx1}, 16'h0000);
        check("rd0_after_reset", v0, 16'h0000);

        // LOAD / READ / INC x10
        spi_load(6'd2, 16'hBEEF);
        read_check("ld_ch2", 6'd2, 16'hBEEF, 16'hBEEF);
        for (int k = 0; k < 10; k++) begin
            spi_cmd(8'h82, 4'b0000);
        end
        read_check("inc10_ch2", 6'd2, 16'hBEF9, 16'hBEF9);

        // evt at max: wrap vs saturate
        spi_load(6'd1, 16'hFFFF);
        pulse_evt(4'b0010);
        read_check("evt_max_ch1", 6'd1, 16'h0000, 16'hFFFF);

        // SPI INC and evt in the same clk from 0xFFFE
        spi_load(6'd1, 16'hFFFE);
        spi_cmd(8'h81, 4'b0010);
        read_check("inc_evt_ch1", 6'd1, 16'h0000, 16'hFFFF);

        // CLEAR beats a same-clk evt pulse
        spi_load(6'd0, 16'h0050);
        read_check("ld_ch0", 6'd0, 16'h0050, 16'h0050);
        spi_cmd(8'h40, 4'b0001);
        read_check("clr_evt_ch0", 6'd0, 16'h0000, 16'h0000);

        // Abort partial LOAD after 12 payload bits
        spi_load(6'd3, 16'h1234);
        frame_start();
        xfer_bits(8'hC3, 8, 4'b0000, c0, c1);
        xfer_bits(8'hAB, 8, 4'b0000, c0, c1);
        xfer_bits(8'hCD, 4, 4'b0000, c0, c1);
        frame_stop();
        read_check("abort_ld_ch3", 6'd3, 16'h1234, 16'h1234);

        // Abort after 4 command bits of a CLEAR ch2
        frame_start();
        xfer_bits(8'h42, 4, 4'b0000, c0, c1);
        frame_stop();
        read_check("abort_cmd_ch0", 6'd0, 16'h0000, 16'h0000);
        read_check("abort_cmd_ch1", 6'd1, 16'h0000, 16'hFFFF);
        read_check("abort_cmd_ch2", 6'd2, 16'hBEF9, 16'hBEF9);
        read_check("abort_cmd_ch3", 6'd3, 16'h1234, 16'h1234);

        // Invalid channel LOAD has no effect; READ returns zeros
        spi_load(6'h3F, 16'hAAAA);
        read_check("inval_ch0", 6'd0, 16'h0000, 16'h0000);
        read_check("inval_ch1", 6'd1, 16'h0000, 16'hFFFF);
        read_check("inval_ch2", 6'd2, 16'hBEF9, 16'hBEF9);
        read_check("inval_ch3", 6'd3, 16'h1234, 16'h1234);
        read_check("inval_rd3f", 6'h3F, 16'h0000, 16'h0000);

        // Snapshot: three evt pulses during shift-out do not alter data
        spi_load(6'd0, 16'h00FF);
        fork
            spi_read(6'd0, v0, v1);
            begin
                #(19*HALF);
                repeat (3) pulse_evt(4'b0001);
            end
        join
        check("snap_wrap", v0, 16'h00FF);
        check("snap_sat", v1, 16'h00FF);
        read_check("snap_after", 6'd0, 16'h0102, 16'h0102);

        // Reset in the middle of a READ of ch2 (0xBEF9)
        frame_start();
        xfer_bits(8'h02, 8, 4'b0000, c0, c1);
        xfer_bits(8'h00, 2, 4'b0000, c0, c1);
        check("rd_pre_rst_bits", {c0, c1}, 16'h8080);
        #(HALF);
        check("rd_pre_rst_miso", {14'h0, miso0, miso1}, 16'h0003);
        rst = 1'b1;
        #1;
        check("rd_rst_miso", {14'h0, miso0, miso1}, 16'h0000);
        #(3*CLK_P - 1);
        rst = 1'b0;
        xfer_bits(8'hFF, 6, 4'b0000, c0, c1);
        check("post_rst_tail_a", {c0, c1}, 16'h0000);
        xfer_bits(8'hFF, 8, 4'b0000, c0, c1);
        check("post_rst_tail_b", {c0, c1}, 16'h0000);
        frame_stop();
        read_check("post_rst_ch0", 6'd0, 16'h0000, 16'h0000);
        read_check("post_rst_ch1", 6'd1, 16'h0000, 16'h0000);
        read_check("post_rst_ch2", 6'd2, 16'h0000, 16'h0000);
        read_check("post_rst_ch3", 6'd3, 16'h0000, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
